// File: rtl/param_shift_counter.sv
// Multi-mode WIDTH-bit shift counter: ring, Johnson or Fibonacci LFSR, with load, enable, direction and a wrap pulse.
// Latency: one cycle from reset/load/en to count and wrap; both outputs are registered.
// Backpressure: none; the counter steps every cycle en is high. SC_ILLEGAL_RECOVER_EN adds illegal-state self-correction.
module param_shift_counter #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    localparam logic [1:0] MODE_RING    = 2'b00;
    localparam logic [1:0] MODE_JOHNSON = 2'b01;
    localparam logic [1:0] MODE_LFSR    = 2'b10;

    localparam logic [WIDTH-1:0] SEED_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] SEED_ZERO = '0;

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] ring_left, ring_right;
    logic [WIDTH-1:0] john_left, john_right;
    logic [WIDTH-1:0] lfsr_next;
    logic             lfsr_fb;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] seed;
    logic             stepping;

    assign ring_left  = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
    assign ring_right = {count_q[0], count_q[WIDTH-1:1]};
    assign john_left  = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
    assign john_right = {~count_q[0], count_q[WIDTH-1:1]};
    assign lfsr_fb    = ^(count_q & TAPS);
    assign lfsr_next  = {count_q[WIDTH-2:0], lfsr_fb};

`ifdef SC_ILLEGAL_RECOVER_EN
    // A legal Johnson code has at most two circular bit transitions (one 0/1 boundary each way round).
    logic [WIDTH-1:0] ring_lsb_clr;
    logic [WIDTH-1:0] john_diff, john_diff_1, john_diff_2;
    logic             ring_legal, john_legal, lfsr_legal;

    assign ring_lsb_clr = count_q & (count_q - WIDTH'(1));
    assign ring_legal   = (count_q != '0) && (ring_lsb_clr == '0);
    assign john_diff    = count_q ^ {count_q[0], count_q[WIDTH-1:1]};
    assign john_diff_1  = john_diff & (john_diff - WIDTH'(1));
    assign john_diff_2  = john_diff_1 & (john_diff_1 - WIDTH'(1));
    assign john_legal   = (john_diff_2 == '0);
    assign lfsr_legal   = (count_q != '0);
`endif

    always_comb begin
        seed     = SEED_ONE;
        step_val = count_q;
        stepping = en && (mode != 2'b11);
        case (mode)
            MODE_RING: begin
                seed     = SEED_ONE;
                step_val = dir ? ring_right : ring_left;
`ifdef SC_ILLEGAL_RECOVER_EN
                if (!ring_legal) begin
                    step_val = SEED_ONE;
                end
`endif
            end
            MODE_JOHNSON: begin
                seed     = SEED_ZERO;
                step_val = dir ? john_right : john_left;
`ifdef SC_ILLEGAL_RECOVER_EN
                if (!john_legal) begin
                    step_val = SEED_ZERO;
                end
`endif
            end
            MODE_LFSR: begin
                seed     = SEED_ONE;
                step_val = lfsr_next;
`ifdef SC_ILLEGAL_RECOVER_EN
                if (!lfsr_legal) begin
                    step_val = SEED_ONE;
                end
`endif
            end
            default: begin
                seed     = SEED_ONE;
                step_val = count_q;
            end
        endcase
    end

    // Load outranks stepping; reset outranks both inside the register process.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (load) begin
            count_d = load_val;
        end else if (stepping) begin
            count_d = step_val;
            wrap_d  = (step_val == seed);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_param_shift_counter.sv
// Directed table-driven bench for param_shift_counter at WIDTH=8 with the default LFSR taps.
module tb_param_shift_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [7:0] count;
    logic       wrap;

    int checks = 0;
    int errors = 0;

    param_shift_counter #(.WIDTH(8), .TAPS(8'hB8), .RESET_VAL(8'h01)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic [1:0] mode;
        logic       dir;
        logic [7:0] ec;
        logic       ew;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic ld, input logic [7:0] lv,
                                input logic e, input logic [1:0] m, input logic d,
                                input logic [7:0] ec, input logic ew);
        vec_t v;
        v.rst = rst; v.ld = ld; v.lv = lv; v.en = e; v.mode = m; v.dir = d;
        v.ec = ec; v.ew = ew;
        vecs.push_back(v);
    endfunction

    task automatic step_cycle(input logic rst, input logic ld, input logic [7:0] lv,
                              input logic e, input logic [1:0] m, input logic d);
        @(negedge clk);
        reset = rst; load = ld; load_val = lv; en = e; mode = m; dir = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] ec, input logic ew);
        checks++;
        if (count !== ec || wrap !== ew) begin
            errors++;
            $display("FAIL %s: got count=%02h wrap=%0b, expected count=%02h wrap=%0b",
                     name, count, wrap, ec, ew);
        end
    endtask

    logic [7:0] jl_seq[16];
    logic [7:0] jr_seq[16];
    logic [7:0] model;
    logic       seen[256];

    initial begin
        jl_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                   8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        jr_seq = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                   8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00};

        // Reset for two cycles, then ring left through one full period and one step past.
        add(1, 0, 8'h00, 0, 2'b00, 0, 8'h01, 0);
        add(1, 0, 8'h00, 0, 2'b00, 0, 8'h01, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h02, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h04, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h08, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h10, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h20, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h40, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h80, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h01, 1);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h02, 0);

        // Johnson: load 00 then a full period left, then a full period right.
        add(0, 1, 8'h00, 1, 2'b01, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) add(0, 0, 8'h00, 1, 2'b01, 0, jl_seq[i], i == 15);
        for (int i = 0; i < 16; i++) add(0, 0, 8'h00, 1, 2'b01, 1, jr_seq[i], i == 15);

        // Ring at 04: en low, then hold mode, then load, then reset beating load.
        add(1, 0, 8'h00, 1, 2'b00, 0, 8'h01, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h02, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h04, 0);
        add(0, 0, 8'h00, 0, 2'b00, 0, 8'h04, 0);
        add(0, 0, 8'h00, 0, 2'b00, 0, 8'h04, 0);
        add(0, 0, 8'h00, 0, 2'b00, 0, 8'h04, 0);
        add(0, 0, 8'h00, 1, 2'b11, 0, 8'h04, 0);
        add(0, 0, 8'h00, 1, 2'b11, 0, 8'h04, 0);
        add(0, 1, 8'h5A, 1, 2'b11, 0, 8'h5A, 0);
        add(1, 1, 8'h5A, 1, 2'b00, 0, 8'h01, 0);

        // Direction change mid-run, ring-right wrap, mid-sequence reset.
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h02, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h04, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h08, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h10, 0);
        add(0, 0, 8'h00, 1, 2'b00, 1, 8'h08, 0);
        add(0, 0, 8'h00, 1, 2'b00, 1, 8'h04, 0);
        add(0, 0, 8'h00, 1, 2'b00, 1, 8'h02, 0);
        add(0, 0, 8'h00, 1, 2'b00, 1, 8'h01, 1);
        add(0, 0, 8'h00, 1, 2'b00, 1, 8'h80, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h01, 1);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h02, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h04, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h08, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h10, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h20, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h40, 0);
        add(1, 0, 8'h00, 1, 2'b00, 0, 8'h01, 0);

        // Mode change mid-run: ring value 01 stepped by the Johnson rule.
        add(0, 0, 8'h00, 1, 2'b01, 0, 8'h03, 0);
        add(0, 0, 8'h00, 1, 2'b01, 0, 8'h07, 0);

        // Illegal states: zero LFSR and non-one-hot ring.
        add(0, 1, 8'h00, 1, 2'b10, 0, 8'h00, 0);
`ifdef SC_ILLEGAL_RECOVER_EN
        add(0, 0, 8'h00, 1, 2'b10, 0, 8'h01, 1);
        add(0, 0, 8'h00, 1, 2'b10, 0, 8'h02, 0);
`else
        add(0, 0, 8'h00, 1, 2'b10, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 2'b10, 0, 8'h00, 0);
        add(0, 0, 8'h00, 1, 2'b10, 0, 8'h00, 0);
`endif
        add(0, 1, 8'h33, 1, 2'b00, 0, 8'h33, 0);
`ifdef SC_ILLEGAL_RECOVER_EN
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h01, 1);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h02, 0);
`else
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h66, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'hCC, 0);
        add(0, 0, 8'h00, 1, 2'b00, 0, 8'h99, 0);
`endif

        foreach (vecs[i]) begin
            step_cycle(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].mode, vecs[i].dir);
            check($sformatf("vec%0d", i), vecs[i].ec, vecs[i].ew);
        end

        // LFSR full period from reset: independent Fibonacci model, no repeats, single wrap at step 255.
        step_cycle(1, 0, 8'h00, 1, 2'b10, 0);
        check("lfsr_reset", 8'h01, 1'b0);
        model = 8'h01;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[8'h01] = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            model = {model[6:0], ^(model & 8'hB8)};
            step_cycle(0, 0, 8'h00, 1, 2'b10, 0);
            check($sformatf("lfsr_step%0d", i), model, i == 255);
            if (i < 255) begin
                checks++;
                if (seen[count]) begin
                    errors++;
                    $display("FAIL lfsr_repeat: value %02h seen again at step %0d, required unique", count, i);
                end
                seen[count] = 1'b1;
            end
        end
        step_cycle(0, 0, 8'h00, 1, 2'b10, 0);
        check("lfsr_after_wrap", 8'h02, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_shift_counter.md
Name: param_shift_counter

Overview:
Parametrised multi-mode shift counter, the successor to the fixed 8-bit shift counter.
- Generates ring (one-hot), Johnson (twisted-ring) or maximal-length LFSR sequences of WIDTH bits.
- Runtime controls: direction, enable and parallel load.
- Emits a wrap pulse when the sequence returns to its mode seed.
- Used as a sequencer / pattern source for lab datapaths and LED/scan drivers.

Parameters:
WIDTH, 8, counter width in bits; legal range 2..32.
TAPS, 8'hB8, LFSR tap mask, WIDTH bits; bit i set means count[i] feeds the XOR; default gives x^8+x^6+x^5+x^4+1.
RESET_VAL, 1, count value loaded on reset, WIDTH bits.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  advance one step per cycle while high.
mode  input  2  00 ring, 01 Johnson, 10 LFSR, 11 hold.
dir  input  1  0 shift toward MSB (left), 1 toward LSB (right); ignored in LFSR mode.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value loaded when load=1.
count  output  WIDTH  registered counter state.
wrap  output  1  registered one-cycle pulse: the last step produced the mode seed.

Behaviour:
- One clock (clk). reset is synchronous and active-high; there is no asynchronous path.
- Update priority per rising edge: reset > load > (en and mode!=11) > hold.
- Reset: count=RESET_VAL, wrap=0. Reset mid-sequence discards state the same edge.
- Load: count=load_val, wrap=0, regardless of en or mode.
- Mode seeds: ring seed = 1 (LSB set), Johnson seed = 0, LFSR seed = 1.
- Ring left: count <= {count[W-2:0], count[W-1]}. Ring right: count <= {count[0], count[W-1:1]}. Period WIDTH.
- Johnson left: count <= {count[W-2:0], ~count[W-1]}. Johnson right: count <= {~count[0], count[W-1:1]}. Period 2*WIDTH.
- LFSR (Fibonacci, always left): fb = ^(count & TAPS); count <= {count[W-2:0], fb}. Period 2^WIDTH-1 for a maximal TAPS.
- Hold (mode=11) or en=0: count unchanged, wrap=0.
- wrap: set to 1 on the same edge count steps (not loads or resets) to a value equal to the current mode's seed; otherwise 0. It is never high two cycles in a row unless the sequence period is 1.
- Mode change mid-run: no reinitialisation. The next step applies the new mode's rule to the current count.
- dir change mid-run: takes effect on the next step; no reset of the pattern.
- Latency: one cycle from en/load/reset to count; no combinational input-to-output path.
- Illegal states without the optional feature: behaviour is exactly the shift rules above.
  - A zero ring stays zero.
  - An all-zero LFSR locks at zero.
  - A non-one-hot ring rotates as-is.

Optional Feature:
Macro SC_ILLEGAL_RECOVER_EN.
- Defined: self-correction on a step.
  - Ring mode with count not exactly one-hot: next count = 1, wrap=1.
  - LFSR mode with count==0: next count = 1, wrap=1.
  - Johnson mode with count not a legal Johnson code (more than one 0/1 boundary, circularly): next count = 0, wrap=1.
  - Legal states are unaffected.
- Undefined: no recovery logic is synthesised; illegal states propagate per the shift rules.

Test Plan:
1. WIDTH=8, reset 2 cycles, mode=00, dir=0, en=1 -> count 01,02,04,08,10,20,40,80,01; wrap=1 only on the return to 01 (8th step).
2. load=1 with load_val=00, mode=01, dir=0, en=1 -> 01,03,07,0F,1F,3F,7F,FF,FE,FC,F8,F0,E0,C0,80,00; wrap=1 on the 16th step only. Repeat with dir=1 from 00 -> 80,C0,E0,...
3. mode=10, reset (count=01), en=1 -> 01,02,04,08,11,...; wrap after exactly 255 steps; no value repeats within the period.
4. Ring running at 04: drop en for 3 cycles, then set mode=11 -> count holds 04 with wrap=0. Then assert load=1 (load_val=5A) and reset together -> count=01 (reset wins).
5. Ring left at 10: toggle dir=1 -> next 08, then 04. Mid-sequence reset at count=40 -> next count 01.
6. SC_ILLEGAL_RECOVER_EN defined:
   - load 00 in LFSR -> next step 01, wrap=1.
   - load 0x33 in ring -> next step 01, wrap=1.
   Macro undefined: load 00 in LFSR -> stays 00 indefinitely.
